uart_baud_gen_frac: RTL

Programmable fractional-N baud tick generator for the UART. It is the runtime-configurable successor to the fixed-divisor generator. It produces a one-cycle oversample tick (rxclk_en) and a one-cycle bit tick (txclk_en) from clk using an integer+fractional divisor and a selectable oversampling ratio. RX and TX use independent prescalers, so the receiver can re-phase its tick on start-bit detection without disturbing transmit timing.

---
 rtl/uart_baud_gen_frac.sv | 96 +++++++++
 1 files changed

// File: rtl/uart_baud_gen_frac.sv
// uart_baud_gen_frac: fractional-N RX oversample and TX bit tick generator with independent prescalers
module uart_baud_gen_frac #(
  parameter int DIV_INT_W = 16,
  parameter int DIV_FRAC_W = 4,
  parameter int OSR_W = 4,
  parameter int DEF_DIV_INT = 27,
  parameter int DEF_DIV_FRAC = 2,
  parameter int DEF_OSR_M1 = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  cfg_load,
  input  logic [DIV_INT_W-1:0]  div_int,
  input  logic [DIV_FRAC_W-1:0] div_frac,
  input  logic [OSR_W-1:0]      osr_m1,
  input  logic                  rx_resync,
  output logic                  rxclk_en,
  output logic                  txclk_en
);
  localparam int CW = DIV_INT_W + 1;
  localparam logic [CW-1:0] DEF_EFF = (DEF_DIV_INT < 2) ? CW'(2) : CW'(DEF_DIV_INT);
  logic [DIV_INT_W-1:0]  act_int, nxt_int;
  logic [DIV_FRAC_W-1:0] act_frac, nxt_frac, rx_acc, tx_acc;
  logic [OSR_W-1:0]      act_osr, nxt_osr, osr_eff, os_cnt;
  logic [CW-1:0]         div_eff, rx_cnt, tx_cnt, rx_reload, tx_reload;
  logic [DIV_FRAC_W:0]   rx_sum, tx_sum;
  // Reloads see the values cfg_load is about to capture, so a load coinciding with a tick governs the new interval
  always_comb begin
    nxt_int = cfg_load ? div_int : act_int;
    nxt_frac = cfg_load ? div_frac : act_frac;
    nxt_osr = cfg_load ? osr_m1 : act_osr;
    div_eff = (nxt_int < DIV_INT_W'(2)) ? CW'(2) : CW'(nxt_int);
    osr_eff = (nxt_osr < OSR_W'(3)) ? OSR_W'(3) : nxt_osr;
    rx_sum = {1'b0, rx_acc} + {1'b0, nxt_frac};
    tx_sum = {1'b0, tx_acc} + {1'b0, nxt_frac};
    rx_reload = div_eff + CW'(rx_sum[DIV_FRAC_W]) - CW'(1);
    tx_reload = div_eff + CW'(tx_sum[DIV_FRAC_W]) - CW'(1);
  end
  // Active configuration registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_int <= DIV_INT_W'(DEF_DIV_INT);
      act_frac <= DIV_FRAC_W'(DEF_DIV_FRAC);
      act_osr <= OSR_W'(DEF_OSR_M1);
    end else if (cfg_load) begin
      act_int <= div_int;
      act_frac <= div_frac;
      act_osr <= osr_m1;
    end
  end
  // RX prescaler: down-counter of remaining edges; resync restarts it but never suppresses a due tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_cnt <= DEF_EFF - CW'(1);
      rx_acc <= '0;
      rxclk_en <= 1'b0;
    end else if (!enable) begin
      rx_cnt <= div_eff - CW'(1);
      rx_acc <= '0;
      rxclk_en <= 1'b0;
    end else begin
      rxclk_en <= (rx_cnt == '0);
      if (rx_resync) begin
        rx_cnt <= div_eff - CW'(1);
        rx_acc <= '0;
      end else if (rx_cnt == '0) begin
        rx_cnt <= rx_reload;
        rx_acc <= rx_sum[DIV_FRAC_W-1:0];
      end else
        rx_cnt <= rx_cnt - CW'(1);
    end
  end
  // TX prescaler plus oversample counter; >= lets a shrunken osr wrap on the next tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_cnt <= DEF_EFF - CW'(1);
      tx_acc <= '0;
      os_cnt <= '0;
      txclk_en <= 1'b0;
    end else if (!enable) begin
      tx_cnt <= div_eff - CW'(1);
      tx_acc <= '0;
      os_cnt <= '0;
      txclk_en <= 1'b0;
    end else begin
      txclk_en <= (tx_cnt == '0) && (os_cnt >= osr_eff);
      if (tx_cnt == '0) begin
        tx_cnt <= tx_reload;
        tx_acc <= tx_sum[DIV_FRAC_W-1:0];
        os_cnt <= (os_cnt >= osr_eff) ? '0 : os_cnt + OSR_W'(1);
      end else
        tx_cnt <= tx_cnt - CW'(1);
    end
  end
endmodule
